// File: rtl/sram1rw_pkg.sv
// Shared types and default geometry for the single-port SRAM arbiter slice.
// The command struct is sized for the SRAM1RW256x32 macro this block fronts.
package sram1rw_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] a;
    logic                  web;
    logic                  csb;
    logic [DATA_W_DEF-1:0] i;
  } sram_cmd_t;

  // Deselected, read-polarity command the macro sees out of reset
  localparam sram_cmd_t CMD_IDLE = '{a: '0, web: 1'b1, csb: 1'b1, i: '0};

endpackage

// File: rtl/sram1rw_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping around; the pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NPORTS-1:0] o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Walk the ports starting at the pointer and keep only the first hit
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NPORTS; off++) begin
      w_idx = PTR_W'((int'(i_ptr) + off) % NPORTS);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram1rw_arbiter.sv
// Round-robin front end sharing one SRAM1RW256x32 macro between NPORTS clients,
// with an optional zero-fill of the whole array after reset.
module sram1rw_arbiter
  import sram1rw_pkg::*;
#(
  parameter int NPORTS         = 2,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid,
  output logic [NPORTS-1:0]        req_ready,
  input  logic [NPORTS-1:0]        req_we,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  input  logic [NPORTS*DATA_W-1:0] req_wdata,
  output logic [NPORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     init_done,
  output logic [ADDR_W-1:0]        sram_a,
  output logic                     sram_web,
  output logic                     sram_csb,
  output logic                     sram_oeb,
  output logic [DATA_W-1:0]        sram_i,
  input  logic [DATA_W-1:0]        sram_o
);

  localparam int PTR_W = $clog2(NPORTS);
  localparam logic [NPORTS-1:0] PORT0_ONEHOT = {{(NPORTS-1){1'b0}}, 1'b1};

  state_e            r_state;
  sram_cmd_t         r_cmd;
  logic              r_oeb;
  logic [PTR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_clrAddr;
  logic              r_initDone;

  logic              r_tag1Rd;
  logic              r_tag2Rd;
  logic [PTR_W-1:0]  r_tag1Port;
  logic [PTR_W-1:0]  r_tag2Port;
  logic [NPORTS-1:0] r_rspValid;
  logic [DATA_W-1:0] r_rspData;

  logic [NPORTS-1:0] w_reqMasked;
  logic [NPORTS-1:0] w_grant;
  logic              w_hs;
  logic [PTR_W-1:0]  w_gntIdx;
  logic [PTR_W-1:0]  w_nextPtr;
  logic              w_gntWe;
  logic [ADDR_W-1:0] w_gntAddr;
  logic [DATA_W-1:0] w_gntData;

  // Nobody is offered a grant while the clear sequencer owns the macro
  assign w_reqMasked = (r_state == RUN) ? req_valid : '0;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .PTR_W  (PTR_W)
  ) u_rr (
    .i_req   (w_reqMasked),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_hs      = |w_grant;

  always_comb begin
    w_gntIdx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (w_grant[k]) begin
        w_gntIdx = PTR_W'(k);
      end
    end
  end

  assign w_nextPtr = (w_gntIdx == PTR_W'(NPORTS - 1)) ? '0 : w_gntIdx + 1'b1;
  assign w_gntWe   = req_we[w_gntIdx];
  assign w_gntAddr = req_addr[w_gntIdx*ADDR_W +: ADDR_W];
  assign w_gntData = req_wdata[w_gntIdx*DATA_W +: DATA_W];

  // Main FSM: zero-fill sweep in INIT, then one registered command per granted handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      r_cmd      <= CMD_IDLE;
      r_oeb      <= 1'b0;
      r_ptr      <= '0;
      r_clrAddr  <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_oeb <= 1'b0;
      case (r_state)
        INIT: begin
          r_cmd.a   <= r_clrAddr;
          r_cmd.web <= 1'b0;
          r_cmd.csb <= 1'b0;
          r_cmd.i   <= '0;
          r_clrAddr <= r_clrAddr + 1'b1;
          if (r_clrAddr == ADDR_W'(DEPTH - 1)) begin
            r_state    <= RUN;
            r_initDone <= 1'b1;
          end
        end
        RUN: begin
          r_initDone <= 1'b1;
          if (w_hs) begin
            r_cmd.a   <= w_gntAddr;
            r_cmd.web <= ~w_gntWe;
            r_cmd.csb <= 1'b0;
            r_cmd.i   <= w_gntData;
            r_ptr     <= w_nextPtr;
          end else begin
            r_cmd.web <= 1'b1;
            r_cmd.csb <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read tags ride two stages so the port id lines up with sram_o being sampled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag1Rd   <= 1'b0;
      r_tag1Port <= '0;
      r_tag2Rd   <= 1'b0;
      r_tag2Port <= '0;
      r_rspValid <= '0;
      r_rspData  <= '0;
    end else begin
      r_tag1Rd   <= w_hs & ~w_gntWe;
      r_tag1Port <= w_gntIdx;
      r_tag2Rd   <= r_tag1Rd;
      r_tag2Port <= r_tag1Port;
      r_rspValid <= r_tag2Rd ? (PORT0_ONEHOT << r_tag2Port) : '0;
      if (r_tag2Rd) begin
        r_rspData <= sram_o;
      end
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspData;
  assign init_done = r_initDone;
  assign sram_a    = r_cmd.a;
  assign sram_web  = r_cmd.web;
  assign sram_csb  = r_cmd.csb;
  assign sram_i    = r_cmd.i;
  assign sram_oeb  = r_oeb;

endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Directed bench for sram1rw_arbiter: behavioural SRAM macro, clear sweep,
// table-driven arbitration/response vectors, mid-flight reset and no-clear mode.
module tb_sram1rw_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [1:0]  reqWe;
  logic [15:0] reqAddr;
  logic [63:0] reqWdata;
  logic [1:0]  rspValid;
  logic [31:0] rspRdata;
  logic        initDone;
  logic [7:0]  sramA;
  logic        sramWeb;
  logic        sramCsb;
  logic        sramOeb;
  logic [31:0] sramI;
  logic [31:0] sramO;

  logic        rst2;
  logic [1:0]  reqValid2;
  logic [1:0]  reqReady2;
  logic [1:0]  reqWe2;
  logic [15:0] reqAddr2;
  logic [63:0] reqWdata2;
  logic [1:0]  rspValid2;
  logic [31:0] rspRdata2;
  logic        initDone2;
  logic [7:0]  sramA2;
  logic        sramWeb2;
  logic        sramCsb2;
  logic        sramOeb2;
  logic [31:0] sramI2;
  logic [31:0] sramO2;

  logic [31:0] mem [256];
  int          errors;
  int          checks;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  expReady;
    logic [1:0]  expRsp;
    logic [31:0] expData;
    logic        expCsb;
    logic        expWeb;
    logic [7:0]  expA;
    logic [31:0] expI;
  } vec_t;

  vec_t vecs [14];

  sram1rw_arbiter #(.NPORTS(2), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rspValid), .rsp_rdata(rspRdata),
    .init_done(initDone), .sram_a(sramA), .sram_web(sramWeb), .sram_csb(sramCsb),
    .sram_oeb(sramOeb), .sram_i(sramI), .sram_o(sramO)
  );

  sram1rw_arbiter #(.NPORTS(2), .CLEAR_ON_RESET(0)) dutNoClear (
    .clk(clk), .rst(rst2), .req_valid(reqValid2), .req_ready(reqReady2), .req_we(reqWe2),
    .req_addr(reqAddr2), .req_wdata(reqWdata2), .rsp_valid(rspValid2), .rsp_rdata(rspRdata2),
    .init_done(initDone2), .sram_a(sramA2), .sram_web(sramWeb2), .sram_csb(sramCsb2),
    .sram_oeb(sramOeb2), .sram_i(sramI2), .sram_o(sramO2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural macro: command visible during a cycle is sampled at its closing edge
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hBAD0_0000 | i;
    sramO = 32'h0;
  end

  always @(posedge clk) begin
    if (!sramCsb) begin
      if (!sramWeb) mem[sramA] <= sramI;
      else          sramO <= mem[sramA];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    reqValid = v;
    reqWe    = we;
    reqAddr  = {a1, a0};
    reqWdata = {d1, d0};
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    rst2      = 1'b1;
    reqValid2 = 2'b00;
    reqWe2    = 2'b00;
    reqAddr2  = 16'h0;
    reqWdata2 = 64'h0;
    sramO2    = 32'h0;
    applyStimulus(2'b11, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    //                  valid  we     a0     a1     d0            d1            rdy    rsp    data          csb   web   a      i
    vecs[0]  = '{2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0,        2'b01, 2'b00, 32'h0,        1'b0, 1'b0, 8'h10, 32'hDEADBEEF};
    vecs[1]  = '{2'b01, 2'b00, 8'h10, 8'h00, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0,        1'b0, 1'b1, 8'h10, 32'h0};
    vecs[2]  = '{2'b10, 2'b10, 8'h00, 8'h01, 32'h0,        32'h11111111, 2'b10, 2'b00, 32'h0,        1'b0, 1'b0, 8'h01, 32'h11111111};
    vecs[3]  = '{2'b01, 2'b01, 8'h02, 8'h00, 32'h22222222, 32'h0,        2'b01, 2'b00, 32'h0,        1'b0, 1'b0, 8'h02, 32'h22222222};
    vecs[4]  = '{2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        32'h0,        2'b10, 2'b01, 32'hDEADBEEF, 1'b0, 1'b1, 8'h02, 32'h0};
    vecs[5]  = '{2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        32'h0,        2'b01, 2'b00, 32'hDEADBEEF, 1'b0, 1'b1, 8'h01, 32'h0};
    vecs[6]  = '{2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        32'h0,        2'b10, 2'b00, 32'hDEADBEEF, 1'b0, 1'b1, 8'h02, 32'h0};
    vecs[7]  = '{2'b11, 2'b00, 8'h01, 8'h02, 32'h0,        32'h0,        2'b01, 2'b10, 32'h22222222, 1'b0, 1'b1, 8'h01, 32'h0};
    vecs[8]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b01, 32'h11111111, 1'b1, 1'b1, 8'h01, 32'h0};
    vecs[9]  = '{2'b01, 2'b00, 8'hFF, 8'h00, 32'h0,        32'h0,        2'b01, 2'b10, 32'h22222222, 1'b0, 1'b1, 8'hFF, 32'h0};
    vecs[10] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b01, 32'h11111111, 1'b1, 1'b1, 8'hFF, 32'h0};
    vecs[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h11111111, 1'b1, 1'b1, 8'hFF, 32'h0};
    vecs[12] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b01, 32'h00000000, 1'b1, 1'b1, 8'hFF, 32'h0};
    vecs[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h00000000, 1'b1, 1'b1, 8'hFF, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {30'h0, reqReady}, 32'h0);
    checkOutput("rst_rsp_valid", {30'h0, rspValid}, 32'h0);
    checkOutput("rst_rsp_rdata", rspRdata, 32'h0);
    checkOutput("rst_init_done", {31'h0, initDone}, 32'h0);
    checkOutput("rst_csb_web", {30'h0, sramCsb, sramWeb}, 32'h3);
    checkOutput("rst_a", {24'h0, sramA}, 32'h0);
    checkOutput("rst_i", sramI, 32'h0);
    checkOutput("rst_oeb", {31'h0, sramOeb}, 32'h0);

    // Clear sweep: 256 zero writes, ready held low while requests are pending
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      checkOutput("init_csb_web_a", {22'h0, sramCsb, sramWeb, sramA}, {22'h0, 2'b00, 8'(k)});
      checkOutput("init_i", sramI, 32'h0);
      checkOutput("init_done_timing", {31'h0, initDone}, 32'(k == 255));
      checkOutput("init_ready", {30'h0, reqReady}, 32'h0);
      if (k == 254) applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    end

    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      applyStimulus(vecs[r].valid, vecs[r].we, vecs[r].a0, vecs[r].a1, vecs[r].d0, vecs[r].d1);
      #1;
      checkOutput($sformatf("vec%0d_ready", r), {30'h0, reqReady}, {30'h0, vecs[r].expReady});
      checkOutput($sformatf("vec%0d_rsp_valid", r), {30'h0, rspValid}, {30'h0, vecs[r].expRsp});
      checkOutput($sformatf("vec%0d_rsp_rdata", r), rspRdata, vecs[r].expData);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_csb_web", r), {30'h0, sramCsb, sramWeb}, {30'h0, vecs[r].expCsb, vecs[r].expWeb});
      checkOutput($sformatf("vec%0d_a", r), {24'h0, sramA}, {24'h0, vecs[r].expA});
      checkOutput($sformatf("vec%0d_i", r), sramI, vecs[r].expI);
      checkOutput($sformatf("vec%0d_oeb", r), {31'h0, sramOeb}, 32'h0);
    end

    // Two reads in flight (port1 then port0), then reset before either responds
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0);
    #1;
    checkOutput("midrst_rsp_valid", {30'h0, rspValid}, 32'h0);
    checkOutput("midrst_init_done", {31'h0, initDone}, 32'h0);
    checkOutput("midrst_csb", {31'h0, sramCsb}, 32'h1);
    checkOutput("midrst_ready", {30'h0, reqReady}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_no_rsp", {30'h0, rspValid}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("restart_csb_web_a", {22'h0, sramCsb, sramWeb, sramA}, 32'h0);
    checkOutput("restart_no_rsp", {30'h0, rspValid}, 32'h0);
    begin
      int budget;
      budget = 0;
      while (!initDone && budget < 300) begin
        @(posedge clk);
        #1;
        budget++;
      end
      checkOutput("restart_init_done", {31'h0, initDone}, 32'h1);
    end
    // Pointer was left at port0 before reset only if it was reset; port1 would win otherwise
    checkOutput("restart_ptr_zero", {30'h0, reqReady}, 32'h1);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);

    // No-clear instance: grant available straight out of reset
    @(negedge clk);
    reqValid2 = 2'b01;
    reqWe2    = 2'b00;
    reqAddr2  = {8'h00, 8'h05};
    rst2      = 1'b0;
    #1;
    checkOutput("noclr_ready", {30'h0, reqReady2}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("noclr_init_done", {31'h0, initDone2}, 32'h1);
    checkOutput("noclr_csb_web_a", {22'h0, sramCsb2, sramWeb2, sramA2}, {22'h0, 2'b01, 8'h05});
    reqValid2 = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
